// File: rtl/alu_spare_remap_pkg.sv
// Shared definitions for the spare-remapping ALU bank: op encodings, lane states,
// scrub vector and the spare allocator.
package alu_spare_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b101;

    typedef enum logic [1:0] {
        LANE_NORMAL = 2'd0,
        LANE_REPLAY = 2'd1,
        LANE_DEAD   = 2'd2
    } lane_state_e;

    localparam logic [31:0] SCRUB_A   = 32'h5A5A5A5A;
    localparam logic [31:0] SCRUB_B   = 32'h0F0F0F0F;
    localparam logic [31:0] SCRUB_EXP = 32'h69696969;

    localparam int MAX_UNITS = 32;

    // Lowest set bit of the free mask, or -1 when no unit is free.
    function automatic int alloc_lowest_free(input logic [MAX_UNITS-1:0] free_mask);
        int pick;
        pick = -1;
        for (int p = MAX_UNITS - 1; p >= 0; p--) begin
            if (free_mask[p]) begin
                pick = p;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/alu_spare_remap_alu_unit.sv
// One combinational physical ALU; unknown op codes produce zero.
module alu_unit
    import alu_spare_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_SLT:  y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_spare_remap.sv
// Fault-tolerant ALU bank: LANES logical lanes remapped onto LANES+SPARES physical ALUs,
// faulted ops replayed on a spare. Define ALU_SPARE_SCRUB_EN for periodic spare scrubbing.
module alu_spare_remap
    import alu_spare_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANES  = 2,
    parameter int SPARES = 2,
    localparam int PHYS  = LANES + SPARES,
    localparam int IDX_W = $clog2(PHYS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES-1:0]        in_valid,
    output logic [LANES-1:0]        in_ready,
    input  logic [LANES*3-1:0]      in_op,
    input  logic [LANES*DATA_W-1:0] in_a,
    input  logic [LANES*DATA_W-1:0] in_b,
    input  logic [PHYS-1:0]         fault_in,
    input  logic                    fault_clr,
    output logic [LANES-1:0]        res_valid,
    output logic [LANES*DATA_W-1:0] res_data,
    output logic [LANES-1:0]        res_err,
    output logic [PHYS-1:0]         fault_map,
    output logic [LANES*IDX_W-1:0]  lane_map,
    output logic [LANES-1:0]        lane_dead,
    output logic [IDX_W:0]          spares_left,
    output logic                    hardware_fault_flag
);

    localparam logic [PHYS-1:0] ALLOC_RST = PHYS'((1 << LANES) - 1);

    lane_state_e       state_q   [LANES];
    lane_state_e       state_d   [LANES];
    logic [IDX_W-1:0]  map_q     [LANES];
    logic [IDX_W-1:0]  map_d     [LANES];
    logic [2:0]        buf_op_q  [LANES];
    logic [2:0]        buf_op_d  [LANES];
    logic [DATA_W-1:0] buf_a_q   [LANES];
    logic [DATA_W-1:0] buf_a_d   [LANES];
    logic [DATA_W-1:0] buf_b_q   [LANES];
    logic [DATA_W-1:0] buf_b_d   [LANES];
    logic [DATA_W-1:0] res_data_q[LANES];
    logic [DATA_W-1:0] res_data_d[LANES];

    logic [PHYS-1:0]  fault_q, fault_d;
    logic [PHYS-1:0]  alloc_q, alloc_d;
    logic [LANES-1:0] res_valid_q, res_valid_d;
    logic [LANES-1:0] res_err_q, res_err_d;
    logic [IDX_W:0]   spares_q, spares_d;
    logic             hw_flag_q, hw_flag_d;
    logic             clr_pend_q, clr_pend_d;

    logic [LANES-1:0]  exec;
    logic [LANES-1:0]  hit;
    logic [2:0]        l_op [LANES];
    logic [DATA_W-1:0] l_a  [LANES];
    logic [DATA_W-1:0] l_b  [LANES];
    logic [2:0]        u_op [PHYS];
    logic [DATA_W-1:0] u_a  [PHYS];
    logic [DATA_W-1:0] u_b  [PHYS];
    logic [DATA_W-1:0] u_res[PHYS];

    // A lane executes either a fresh issue or its buffered replay on lane_map[i].
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            exec[i] = (state_q[i] == LANE_NORMAL && in_valid[i]) || (state_q[i] == LANE_REPLAY);
            if (state_q[i] == LANE_REPLAY) begin
                l_op[i] = buf_op_q[i];
                l_a[i]  = buf_a_q[i];
                l_b[i]  = buf_b_q[i];
            end else begin
                l_op[i] = in_op[i*3 +: 3];
                l_a[i]  = in_a[i*DATA_W +: DATA_W];
                l_b[i]  = in_b[i*DATA_W +: DATA_W];
            end
            hit[i] = exec[i] && fault_in[map_q[i]];
        end
    end

`ifdef ALU_SPARE_SCRUB_EN
    logic [7:0]       scrub_cnt_q, scrub_cnt_d;
    logic             scrub_go;
    logic [IDX_W-1:0] scrub_idx;
    int               scrub_pick;

    // Scrub only in periods where no lane is reallocating.
    always_comb begin
        scrub_cnt_d = scrub_cnt_q + 8'd1;
        scrub_pick  = alloc_lowest_free(MAX_UNITS'(~fault_q & ~alloc_q));
        scrub_go    = (scrub_cnt_q == 8'hFF) && (hit == '0) && (scrub_pick >= 0);
        scrub_idx   = IDX_W'(scrub_pick);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scrub_cnt_q <= '0;
        end else begin
            scrub_cnt_q <= scrub_cnt_d;
        end
    end
`endif

    always_comb begin
        for (int p = 0; p < PHYS; p++) begin
            u_op[p] = OP_ADD;
            u_a[p]  = '0;
            u_b[p]  = '0;
        end
        for (int i = 0; i < LANES; i++) begin
            if (exec[i]) begin
                u_op[map_q[i]] = l_op[i];
                u_a[map_q[i]]  = l_a[i];
                u_b[map_q[i]]  = l_b[i];
            end
        end
`ifdef ALU_SPARE_SCRUB_EN
        if (scrub_go) begin
            u_op[scrub_idx] = OP_ADD;
            u_a[scrub_idx]  = DATA_W'(SCRUB_A);
            u_b[scrub_idx]  = DATA_W'(SCRUB_B);
        end
`endif
    end

    for (genvar p = 0; p < PHYS; p++) begin : g_unit
        alu_unit #(.DATA_W(DATA_W)) u_alu (
            .op(u_op[p]),
            .a (u_a[p]),
            .b (u_b[p]),
            .y (u_res[p])
        );
    end

    always_comb begin
        logic [PHYS-1:0] free;
        logic            replay_any;
        logic            clr_req;
        int              pick;

        fault_d     = fault_q;
        alloc_d     = alloc_q;
        res_valid_d = '0;
        res_err_d   = '0;
        free        = ~fault_q & ~alloc_q;
        replay_any  = 1'b0;
        pick        = -1;
        for (int i = 0; i < LANES; i++) begin
            state_d[i]    = state_q[i];
            map_d[i]      = map_q[i];
            buf_op_d[i]   = buf_op_q[i];
            buf_a_d[i]    = buf_a_q[i];
            buf_b_d[i]    = buf_b_q[i];
            res_data_d[i] = res_data_q[i];
            if (state_q[i] == LANE_REPLAY) begin
                replay_any = 1'b1;
            end
        end

        // Ascending lane order gives lower lanes the lower spares on simultaneous faults.
        for (int i = 0; i < LANES; i++) begin
            if (exec[i]) begin
                if (hit[i]) begin
                    fault_d[map_q[i]] = 1'b1;
                    buf_op_d[i]       = l_op[i];
                    buf_a_d[i]        = l_a[i];
                    buf_b_d[i]        = l_b[i];
                    pick              = alloc_lowest_free(MAX_UNITS'(free));
                    if (pick >= 0) begin
                        map_d[i]               = IDX_W'(pick);
                        alloc_d[IDX_W'(pick)]  = 1'b1;
                        free[IDX_W'(pick)]     = 1'b0;
                        state_d[i]             = LANE_REPLAY;
                    end else begin
                        state_d[i]   = LANE_DEAD;
                        res_err_d[i] = 1'b1;
                    end
                end else begin
                    res_valid_d[i] = 1'b1;
                    res_data_d[i]  = u_res[map_q[i]];
                    state_d[i]     = LANE_NORMAL;
                end
            end
        end

`ifdef ALU_SPARE_SCRUB_EN
        if (scrub_go && ((u_res[scrub_idx] != DATA_W'(SCRUB_EXP)) || fault_in[scrub_idx])) begin
            fault_d[scrub_idx] = 1'b1;
        end
`endif

        // A clear waits until no replay is in flight so no buffered op is lost.
        clr_req    = fault_clr || clr_pend_q;
        clr_pend_d = clr_req && replay_any;
        if (clr_req && !replay_any) begin
            fault_d     = '0;
            alloc_d     = ALLOC_RST;
            res_valid_d = '0;
            res_err_d   = '0;
            for (int i = 0; i < LANES; i++) begin
                state_d[i] = LANE_NORMAL;
                map_d[i]   = IDX_W'(i);
            end
        end

        spares_d = '0;
        for (int p = 0; p < PHYS; p++) begin
            spares_d = spares_d + (IDX_W+1)'(~fault_d[p] & ~alloc_d[p]);
        end
        hw_flag_d = |fault_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q     <= '0;
            alloc_q     <= ALLOC_RST;
            res_valid_q <= '0;
            res_err_q   <= '0;
            spares_q    <= (IDX_W+1)'(SPARES);
            hw_flag_q   <= 1'b0;
            clr_pend_q  <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                state_q[i]    <= LANE_NORMAL;
                map_q[i]      <= IDX_W'(i);
                buf_op_q[i]   <= '0;
                buf_a_q[i]    <= '0;
                buf_b_q[i]    <= '0;
                res_data_q[i] <= '0;
            end
        end else begin
            fault_q     <= fault_d;
            alloc_q     <= alloc_d;
            res_valid_q <= res_valid_d;
            res_err_q   <= res_err_d;
            spares_q    <= spares_d;
            hw_flag_q   <= hw_flag_d;
            clr_pend_q  <= clr_pend_d;
            for (int i = 0; i < LANES; i++) begin
                state_q[i]    <= state_d[i];
                map_q[i]      <= map_d[i];
                buf_op_q[i]   <= buf_op_d[i];
                buf_a_q[i]    <= buf_a_d[i];
                buf_b_q[i]    <= buf_b_d[i];
                res_data_q[i] <= res_data_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            in_ready[i]                    = (state_q[i] == LANE_NORMAL);
            lane_dead[i]                   = (state_q[i] == LANE_DEAD);
            lane_map[i*IDX_W +: IDX_W]     = map_q[i];
            res_data[i*DATA_W +: DATA_W]   = res_data_q[i];
        end
    end

    assign res_valid           = res_valid_q;
    assign res_err             = res_err_q;
    assign fault_map           = fault_q;
    assign spares_left         = spares_q;
    assign hardware_fault_flag = hw_flag_q;

endmodule

// File: tb/tb_alu_spare_remap.sv
// Bench for alu_spare_remap: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural lane/unit model.
module tb_alu_spare_remap;
  localparam int DW     = 32;
  localparam int LANES  = 2;
  localparam int PHYS   = 4;
  localparam int IDX_W  = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [LANES-1:0]       in_valid, in_ready, res_valid, res_err, lane_dead;
  logic [LANES*3-1:0]     in_op;
  logic [LANES*DW-1:0]    in_a, in_b, res_data;
  logic [PHYS-1:0]        fault_in, fault_map;
  logic                   fault_clr, hardware_fault_flag;
  logic [LANES*IDX_W-1:0] lane_map;
  logic [IDX_W:0]         spares_left;

  int n_tests = 0;
  int n_fail  = 0;

  // model: mode 0 = normal, 1 = replaying, 2 = dead
  int          m_mode[LANES];
  int          m_map[LANES];
  bit          m_fault[PHYS];
  bit          m_used[PHYS];
  logic [2:0]  m_bop[LANES];
  logic [DW-1:0] m_ba[LANES], m_bb[LANES], m_rd[LANES];
  bit          m_rv[LANES], m_re[LANES];
  bit          m_pend;

  // clock / reset
  always #5 clk = ~clk;

  alu_spare_remap dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .fault_in(fault_in), .fault_clr(fault_clr),
    .res_valid(res_valid), .res_data(res_data), .res_err(res_err),
    .fault_map(fault_map), .lane_map(lane_map), .lane_dead(lane_dead),
    .spares_left(spares_left), .hardware_fault_flag(hardware_fault_flag)
  );

  function automatic logic [DW-1:0] alu_ref(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return '0;
    endcase
  endfunction

  task automatic model_reset(input bit keep_data);
    for (int l = 0; l < LANES; l++) begin
      m_mode[l] = 0;
      m_map[l]  = l;
      m_rv[l]   = 0;
      m_re[l]   = 0;
      if (!keep_data) m_rd[l] = '0;
    end
    for (int p = 0; p < PHYS; p++) begin
      m_fault[p] = 0;
      m_used[p]  = (p < LANES);
    end
    m_pend = 0;
  endtask

  task automatic model_step();
    bit replay_any;
    bit clr;
    logic [2:0] op;
    logic [DW-1:0] a, b;
    int u, spare;
    if (rst) begin
      model_reset(0);
      return;
    end
    replay_any = 0;
    for (int l = 0; l < LANES; l++) if (m_mode[l] == 1) replay_any = 1;
    clr = fault_clr || m_pend;
    for (int l = 0; l < LANES; l++) begin
      m_rv[l] = 0;
      m_re[l] = 0;
    end
    for (int l = 0; l < LANES; l++) begin
      if ((m_mode[l] == 0 && in_valid[l]) || m_mode[l] == 1) begin
        if (m_mode[l] == 1) begin
          op = m_bop[l]; a = m_ba[l]; b = m_bb[l];
        end else begin
          op = in_op[l*3 +: 3]; a = in_a[l*DW +: DW]; b = in_b[l*DW +: DW];
        end
        u = m_map[l];
        if (fault_in[u]) begin
          m_fault[u] = 1;
          m_bop[l] = op; m_ba[l] = a; m_bb[l] = b;
          spare = -1;
          for (int p = 0; p < PHYS; p++)
            if (spare < 0 && !m_fault[p] && !m_used[p]) spare = p;
          if (spare >= 0) begin
            m_map[l] = spare;
            m_used[spare] = 1;
            m_mode[l] = 1;
          end else begin
            m_mode[l] = 2;
            m_re[l] = 1;
          end
        end else begin
          m_rv[l] = 1;
          m_rd[l] = alu_ref(op, a, b);
          m_mode[l] = 0;
        end
      end
    end
    if (clr && !replay_any) model_reset(1);
    else m_pend = clr;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard compare against the model
  task automatic compare_all();
    logic [LANES*IDX_W-1:0] em;
    logic [PHYS-1:0] ef;
    int sp;
    sp = 0;
    for (int p = 0; p < PHYS; p++) begin
      ef[p] = m_fault[p];
      if (!m_fault[p] && !m_used[p]) sp++;
    end
    for (int l = 0; l < LANES; l++) begin
      em[l*IDX_W +: IDX_W] = IDX_W'(m_map[l]);
      check($sformatf("in_ready%0d", l), in_ready[l], m_mode[l] == 0);
      check($sformatf("lane_dead%0d", l), lane_dead[l], m_mode[l] == 2);
      check($sformatf("res_valid%0d", l), res_valid[l], m_rv[l]);
      check($sformatf("res_err%0d", l), res_err[l], m_re[l]);
      if (m_rv[l]) check($sformatf("res_data%0d", l), res_data[l*DW +: DW], m_rd[l]);
    end
    check("fault_map", fault_map, ef);
    check("lane_map", lane_map, em);
    check("spares_left", spares_left, sp);
    check("hw_flag", hardware_fault_flag, ef != 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  // driver tasks
  task automatic set_idle();
    in_valid = '0; in_op = '0; in_a = '0; in_b = '0; fault_in = '0; fault_clr = 1'b0;
  endtask

  task automatic drive(input int l, input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    in_valid[l] = 1'b1;
    in_op[l*3 +: 3] = op;
    in_a[l*DW +: DW] = a;
    in_b[l*DW +: DW] = b;
  endtask

  function automatic logic [DW-1:0] rand_word();
    case ($urandom_range(0, 4))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    set_idle();
    cycle();
    cycle();
    check("rst_in_ready", in_ready, 2'b11);
    check("rst_lane_map", lane_map, 4'b0100);
    check("rst_spares", spares_left, 3'd2);
    check("rst_res_data", res_data, 64'h0);
    check("rst_fault_map", fault_map, 4'b0000);
    check("rst_hw", hardware_fault_flag, 1'b0);
    rst = 1'b0;

    // clean ADD on lane 0
    drive(0, 3'b000, 32'd5, 32'd3); cycle(); set_idle();
    check("t1_valid", res_valid, 2'b01);
    check("t1_data", res_data[31:0], 32'd8);
    check("t1_map", lane_map, 4'b0100);
    check("t1_fault", fault_map, 4'b0000);

    // fault on unit 0 at issue, replay on unit 2
    drive(0, 3'b000, 32'd5, 32'd3); fault_in = 4'b0001; cycle(); set_idle();
    check("t2_no_valid", res_valid, 2'b00);
    check("t2_map0", lane_map[1:0], 2'd2);
    check("t2_fault", fault_map, 4'b0001);
    check("t2_spares", spares_left, 3'd1);
    check("t2_hw", hardware_fault_flag, 1'b1);
    check("t2_ready", in_ready, 2'b10);
    cycle();
    check("t2_valid", res_valid, 2'b01);
    check("t2_data", res_data[31:0], 32'd8);
    check("t2_ready_back", in_ready, 2'b11);

    // both lanes fault together
    fault_clr = 1'b1; cycle(); set_idle();
    check("t3_clr_map", lane_map, 4'b0100);
    check("t3_clr_spares", spares_left, 3'd2);
    drive(0, 3'b000, 32'd1, 32'd2); drive(1, 3'b011, 32'hF0, 32'h0F); fault_in = 4'b0011;
    cycle(); set_idle();
    check("t3_map", lane_map, 4'b1110);
    check("t3_spares", spares_left, 3'd0);
    check("t3_no_valid", res_valid, 2'b00);
    cycle();
    check("t3_valid", res_valid, 2'b11);
    check("t3_data", res_data, {32'hFF, 32'h3});

    // no spare left: lane 1 dies
    drive(1, 3'b000, 32'd7, 32'd7); fault_in = 4'b1000; cycle(); set_idle();
    check("t4_err", res_err, 2'b10);
    check("t4_dead", lane_dead, 2'b10);
    check("t4_ready", in_ready, 2'b01);
    check("t4_no_valid", res_valid, 2'b00);
    drive(0, 3'b001, 32'd3, 32'd5); cycle(); set_idle();
    check("t4_sub_valid", res_valid, 2'b01);
    check("t4_sub_data", res_data[31:0], 32'hFFFFFFFE);
    check("t4_err_pulse", res_err, 2'b00);

    // fault_clr during replay is deferred
    fault_clr = 1'b1; cycle(); set_idle();
    check("t5_undead", lane_dead, 2'b00);
    drive(0, 3'b010, 32'hF0F0, 32'hFF00); fault_in = 4'b0001; cycle(); set_idle();
    fault_clr = 1'b1; cycle(); set_idle();
    check("t5_replay_valid", res_valid, 2'b01);
    check("t5_replay_data", res_data[31:0], 32'hF000);
    check("t5_map_held", lane_map[1:0], 2'd2);
    check("t5_fault_held", fault_map, 4'b0001);
    cycle();
    check("t5_map_id", lane_map, 4'b0100);
    check("t5_fault_clr", fault_map, 4'b0000);
    check("t5_spares", spares_left, 3'd2);
    check("t5_hw", hardware_fault_flag, 1'b0);

    // signed SLT and undefined op
    drive(0, 3'b101, 32'hFFFFFFFF, 32'd1); drive(1, 3'b111, 32'd5, 32'd5); cycle(); set_idle();
    check("t6_valid", res_valid, 2'b11);
    check("t6_data", res_data, {32'h0, 32'h1});

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      for (int l = 0; l < LANES; l++) begin
        in_valid[l] = ($urandom_range(0, 3) != 0);
        in_op[l*3 +: 3] = 3'($urandom_range(0, 7));
        in_a[l*DW +: DW] = rand_word();
        in_b[l*DW +: DW] = rand_word();
      end
      for (int p = 0; p < PHYS; p++) fault_in[p] = ($urandom_range(0, 19) == 0);
      fault_clr = ($urandom_range(0, 39) == 0);
      cycle();
    end
    rst = 1'b0;
    set_idle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_spare_remap.md
# alu_spare_remap

Parametrised fault-tolerant ALU bank for the execute stage. It generalises the single primary/spare ALU pair to LANES logical lanes backed by LANES+SPARES physical ALUs. A sticky per-unit fault latch and a logical-to-physical remap table steer work away from faulted units. A faulted operation is replayed on a freshly allocated spare, so the result reaching MEM/WB is never corrupted.

## Interface
- DATA_W, 32: operand/result width
- LANES, 2: logical issue lanes
- SPARES, 2: spare physical ALUs; PHYS = LANES+SPARES, IDX_W = $clog2(PHYS)
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  LANES  per-lane issue strobe
- in_ready  out  LANES  lane can accept; issue occurs on in_valid & in_ready
- in_op  in  LANES*3  ALUControl per lane: 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT; others yield 0
- in_a, in_b  in  LANES*DATA_W  operands
- fault_in  in  PHYS  per-physical-unit error indication, qualified only while that unit is executing
- fault_clr  in  1  clear all fault latches, restore identity map
- res_valid  out  LANES  result strobe
- res_data  out  LANES*DATA_W  registered result
- res_err  out  LANES  one-cycle pulse: operation lost, no healthy unit
- fault_map  out  PHYS  sticky fault latch per physical unit
- lane_map  out  LANES*IDX_W  current physical unit per lane
- lane_dead  out  LANES  lane has no unit; in_ready held 0
- spares_left  out  IDX_W+1  healthy unallocated spares
- hardware_fault_flag  out  1  OR of fault_map

## Operation
- Reset: lane_map[i]=i; fault_map=0; spares_left=SPARES; in_ready all 1; res_valid, res_err, lane_dead, res_data, hardware_fault_flag all 0; replay buffer empty.
- Per lane, states NORMAL → REPLAY → NORMAL, or NORMAL → DEAD.
- NORMAL: an issued op computes on unit lane_map[i]; the result registers at the next edge.
- Fault: if fault_in[lane_map[i]]=1 in the issue cycle, then:
  - set fault_map[u], suppress res_valid for that op, latch op/operands into the lane replay buffer;
  - allocate the lowest-index healthy unallocated spare, update lane_map, decrement spares_left;
  - enter REPLAY with in_ready[i]=0.
- REPLAY: re-execute the buffered op on the new unit. A clean run registers the result and returns the lane to NORMAL. A fault on the spare repeats allocation. This is bounded by SPARES.
- No spare at allocation: pulse res_err[i], enter DEAD, set lane_dead[i]; in_ready[i] stays 0 until rst or fault_clr.
- Simultaneous faults on several lanes: allocate in ascending lane order (lane 0 gets the lowest spare).
- fault_in on an idle or unallocated unit is ignored, except in scrub (see Configuration).
- fault_clr: honoured only when no lane is in REPLAY, otherwise deferred to the first cycle with none. Restores reset state apart from res_data.
- Arithmetic: modulo 2^DATA_W wrap, no carry out; SLT is signed and yields 1/0 zero-extended.

## Timing
- NORMAL latency: issue at edge t → res_valid at t+1.
- Faulted op: issue t → replay executes in cycle t+1 → res_valid at t+2. in_ready[i] is low during cycle t+1.
- Each additional spare fault adds 1 cycle.
- lane_map, fault_map and spares_left update at edge t+1 (the edge ending the faulting cycle).
- hardware_fault_flag is registered and rises at t+1.
- rst mid-REPLAY: the buffered op is dropped and no res_valid is issued.

## Configuration
- ALU_SPARE_SCRUB_EN defined:
  - An 8-bit free-running counter runs; on wrap, the lowest-index healthy unallocated spare executes ADD 32'h5A5A5A5A + 32'h0F0F0F0F.
  - A result other than 32'h69696969, or fault_in high, sets its fault_map bit and decrements spares_left.
  - Scrub never delays issue.
  - A spare allocated in the same cycle is skipped; no scrub that period.
- ALU_SPARE_SCRUB_EN undefined: spares are marked faulty only through fault_in during replay; no counter is present.

## Structure
- Package alu_spare_pkg:
  - ALU op encodings as localparams;
  - lane state enum (NORMAL, REPLAY, DEAD);
  - scrub vector constants;
  - the alloc-lowest-free function.
- Sub-module alu_unit: combinational DATA_W ALU. It is instantiated PHYS times. The remap and replay logic stays in the top.

## Test plan
- Reset, lane0 ADD 5,3 → res_data lane0 = 8 at t+1; lane_map = {1,0}; fault_map = 0.
- Lane0 ADD 5,3 with fault_in[0]=1 in the issue cycle:
  - no result at t+1; res_data = 8 at t+2;
  - lane_map lane0 = 2; fault_map = 4'b0001; spares_left = 1; hardware_fault_flag = 1.
- Both lanes fault in the same cycle → lane0→unit2, lane1→unit3, spares_left = 0; both results arrive at t+2.
- With spares_left = 0, lane1 faults → res_err[1] pulse, lane_dead[1] = 1, in_ready[1] = 0. Later ops on lane0 are still correct (SUB 3,5 → 32'hFFFFFFFE).
- fault_clr asserted during REPLAY → takes effect one cycle after the replay completes; map identity, fault_map = 0.
- ALU_SPARE_SCRUB_EN defined, force unit3's result to 32'hDEADBEEF during scrub → fault_map[3] = 1, spares_left decrements; no issue stall.
